// File: rtl/uob_output_arbiter_pkg.sv
// Shared constants and FSM encoding for the unit output buffer arbiter.
// Stream geometry: 2-bit unit symbols, 2'b11 header, dibits packed into 16-bit words.
package uob_output_arbiter_pkg;

  localparam int UNIT_OUTPUT_WIDTH = 2;
  localparam logic [UNIT_OUTPUT_WIDTH-1:0] HDR_CODE = 2'b11;
  localparam int DEF_OUT_N_WORDS = 288;
  localparam int OUT_WORD_W = 16;
  localparam int DIBITS_PER_WORD = OUT_WORD_W / UNIT_OUTPUT_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WAIT_HDR = 3'd2,
    ST_COLLECT  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/uob_output_arbiter_word_packer.sv
// Packs an LSB-first dibit stream into 16-bit words; word/vld are combinational on the 8th dibit.
// No backpressure: a dibit is consumed on every enabled cycle.
module uob_word_packer
  import uob_output_arbiter_pkg::*;
#(
  parameter int N_DIBITS = DEF_OUT_N_WORDS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic [UNIT_OUTPUT_WIDTH-1:0] din,
  output logic [OUT_WORD_W-1:0]        word_dat,
  output logic                         word_vld,
  output logic                         last
);

  localparam int CW = $clog2(N_DIBITS + 1);
  localparam int SW = OUT_WORD_W - UNIT_OUTPUT_WIDTH;

  logic [SW-1:0] sh_q, sh_d;
  logic [CW-1:0] dibit_cnt_q, dibit_cnt_d;

  always_comb begin
    sh_d        = sh_q;
    dibit_cnt_d = dibit_cnt_q;
    if (clr) begin
      dibit_cnt_d = '0;
    end else if (en) begin
      // Newest dibit enters at the top so the first one ends up in bits [1:0].
      sh_d        = {din, sh_q[SW-1:UNIT_OUTPUT_WIDTH]};
      dibit_cnt_d = dibit_cnt_q + 1'b1;
    end
  end

  assign word_dat = {din, sh_q};
  assign word_vld = en && !clr && (dibit_cnt_q[2:0] == 3'b111);
  assign last     = en && !clr && (dibit_cnt_q == CW'(N_DIBITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q        <= '0;
      dibit_cnt_q <= '0;
    end else begin
      sh_q        <= sh_d;
      dibit_cnt_q <= dibit_cnt_d;
    end
  end

endmodule

// File: rtl/uob_output_arbiter.sv
// Round-robin arbiter draining unit output buffers into a 16-bit word stream (id word + packed data).
// out_pkt_ready only gates packet start; optional header timeout via UOB_ARB_HDR_TIMEOUT_EN.
module uob_output_arbiter
  import uob_output_arbiter_pkg::*;
#(
  parameter int N_UNITS     = 4,
  parameter int OUT_N_WORDS = DEF_OUT_N_WORDS,
  parameter int HDR_TIMEOUT = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_UNITS-1:0]                   unit_empty,
  input  logic [UNIT_OUTPUT_WIDTH*N_UNITS-1:0] unit_dout,
  output logic [N_UNITS-1:0]                   unit_rd_en,
  input  logic                                 out_pkt_ready,
  output logic [OUT_WORD_W-1:0]                out_data,
  output logic                                 out_wr_en,
  output logic                                 pkt_done
`ifdef UOB_ARB_HDR_TIMEOUT_EN
  ,
  output logic                                 hdr_err
`endif
);

  localparam int SELW = $clog2(N_UNITS);

  if (N_UNITS < 2 || N_UNITS > 16 || OUT_N_WORDS < 8 || (OUT_N_WORDS % 8) != 0 ||
      HDR_TIMEOUT < 1) begin : g_cfg_err
    $error("uob_output_arbiter: unsupported parameterisation");
  end

  state_t                       state_q, state_d;
  logic [SELW-1:0]              sel_q, sel_d;
  logic [SELW-1:0]              last_grant_q, last_grant_d;
  logic [UNIT_OUTPUT_WIDTH-1:0] din_q, din_d;
  logic [N_UNITS-1:0]           rd_en_q, rd_en_d;
  logic [OUT_WORD_W-1:0]        out_data_q, out_data_d;
  logic                         wr_en_q, wr_en_d;
  logic                         pkt_done_q, pkt_done_d;

  logic [SELW-1:0]              grant;
  logic                         pk_clr, pk_en, pk_vld, pk_last;
  logic [OUT_WORD_W-1:0]        pk_word;

`ifdef UOB_ARB_HDR_TIMEOUT_EN
  localparam int TW = $clog2(HDR_TIMEOUT + 1);
  logic [TW-1:0] hdr_cnt_q, hdr_cnt_d;
  logic          hdr_err_q, hdr_err_d;
`endif

  // First non-empty unit strictly after last_grant, wrapping.
  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_UNITS; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= N_UNITS) idx = idx - N_UNITS;
      if (!found && !unit_empty[idx]) begin
        grant = SELW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    din_d        = unit_dout[UNIT_OUTPUT_WIDTH*sel_q +: UNIT_OUTPUT_WIDTH];
    rd_en_d      = '0;
    out_data_d   = '0;
    wr_en_d      = 1'b0;
    pkt_done_d   = 1'b0;
    pk_clr       = 1'b0;
    pk_en        = 1'b0;
`ifdef UOB_ARB_HDR_TIMEOUT_EN
    hdr_cnt_d    = hdr_cnt_q;
    hdr_err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (out_pkt_ready && !(&unit_empty)) begin
          sel_d   = grant;
          rd_en_d = N_UNITS'(1) << grant;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        state_d = ST_WAIT_HDR;
`ifdef UOB_ARB_HDR_TIMEOUT_EN
        hdr_cnt_d = '0;
`endif
      end
      ST_WAIT_HDR: begin
        if (din_q == HDR_CODE) begin
          out_data_d = OUT_WORD_W'(sel_q);
          wr_en_d    = 1'b1;
          pk_clr     = 1'b1;
          state_d    = ST_COLLECT;
        end
`ifdef UOB_ARB_HDR_TIMEOUT_EN
        else if (hdr_cnt_q == TW'(HDR_TIMEOUT - 1)) begin
          hdr_err_d    = 1'b1;
          last_grant_d = sel_q;
          state_d      = ST_IDLE;
        end else begin
          hdr_cnt_d = hdr_cnt_q + 1'b1;
        end
`endif
      end
      ST_COLLECT: begin
        pk_en = 1'b1;
        if (pk_vld) begin
          out_data_d = pk_word;
          wr_en_d    = 1'b1;
        end
        if (pk_last) begin
          pkt_done_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        last_grant_d = sel_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  uob_word_packer #(
    .N_DIBITS (OUT_N_WORDS)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pk_clr),
    .en       (pk_en),
    .din      (din_q),
    .word_dat (pk_word),
    .word_vld (pk_vld),
    .last     (pk_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      last_grant_q <= SELW'(N_UNITS - 1);
      din_q        <= '0;
      rd_en_q      <= '0;
      out_data_q   <= '0;
      wr_en_q      <= 1'b0;
      pkt_done_q   <= 1'b0;
`ifdef UOB_ARB_HDR_TIMEOUT_EN
      hdr_cnt_q    <= '0;
      hdr_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      din_q        <= din_d;
      rd_en_q      <= rd_en_d;
      out_data_q   <= out_data_d;
      wr_en_q      <= wr_en_d;
      pkt_done_q   <= pkt_done_d;
`ifdef UOB_ARB_HDR_TIMEOUT_EN
      hdr_cnt_q    <= hdr_cnt_d;
      hdr_err_q    <= hdr_err_d;
`endif
    end
  end

  assign unit_rd_en = rd_en_q;
  assign out_data   = out_data_q;
  assign out_wr_en  = wr_en_q;
  assign pkt_done   = pkt_done_q;
`ifdef UOB_ARB_HDR_TIMEOUT_EN
  assign hdr_err    = hdr_err_q;
`endif

endmodule
